// File: rtl/debouncer_pkg.sv
// debouncer_pkg: shared state encoding, default sizing and counter-width helper for the input debouncer
package debouncer_pkg;
  typedef enum logic {ESTAVEL = 1'b0, CONTANDO = 1'b1} estado_t;
  localparam int N_CANAIS_PADRAO = 2;
  localparam int CICLOS_ESTAVEIS_PADRAO = 1000;
  function automatic int largura_cnt(input int ciclos);
    return $clog2(ciclos) > 1 ? $clog2(ciclos) : 1;
  endfunction
endpackage

// File: rtl/debouncer_entrada_if.sv
// debouncer_entrada_if: raw levels in, debounced levels and busy flags out
interface debouncer_entrada_if
  import debouncer_pkg::*;
#(
  parameter int N_CANAIS = N_CANAIS_PADRAO
);
  logic [N_CANAIS-1:0] entrada;
  logic [N_CANAIS-1:0] saida;
  logic [N_CANAIS-1:0] ocupado;
  modport master (output entrada, input saida, ocupado);
  modport slave (input entrada, output saida, ocupado);
endinterface

// File: rtl/debouncer_canal.sv
// debouncer_canal: one channel of synchroniser, stability counter and debounced output register
module debouncer_canal
  import debouncer_pkg::*;
#(
  parameter int CICLOS_ESTAVEIS = CICLOS_ESTAVEIS_PADRAO
) (
  input  logic clk,
  input  logic rst,
  input  logic entrada,
  output logic saida,
  output logic ocupado
);
  localparam int W = largura_cnt(CICLOS_ESTAVEIS);
  localparam logic [W-1:0] LIMITE = W'(CICLOS_ESTAVEIS - 1);
  logic sync0, sync1;
  logic [W-1:0] cnt;
  estado_t estado;
  // a mismatch that survives LIMITE counted edges is accepted on the next one
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      cnt <= '0;
      saida <= 1'b0;
      estado <= ESTAVEL;
    end else begin
      sync0 <= entrada;
      sync1 <= sync0;
      if (sync1 == saida) begin
        cnt <= '0;
        estado <= ESTAVEL;
      end else if (cnt == LIMITE) begin
        saida <= sync1;
        cnt <= '0;
        estado <= ESTAVEL;
      end else begin
        cnt <= cnt + 1'b1;
        estado <= CONTANDO;
      end
    end
  assign ocupado = estado == CONTANDO;
endmodule

// File: rtl/debouncer_entrada.sv
// debouncer_entrada: N independent debounced channels feeding the edge detector
module debouncer_entrada
  import debouncer_pkg::*;
#(
  parameter int N_CANAIS = N_CANAIS_PADRAO,
  parameter int CICLOS_ESTAVEIS = CICLOS_ESTAVEIS_PADRAO
) (
  input logic clk,
  input logic rst,
  debouncer_entrada_if.slave bus
);
  for (genvar c = 0; c < N_CANAIS; c++) begin : g_canal
    debouncer_canal #(.CICLOS_ESTAVEIS(CICLOS_ESTAVEIS)) u_canal (
      .clk(clk),
      .rst(rst),
      .entrada(bus.entrada[c]),
      .saida(bus.saida[c]),
      .ocupado(bus.ocupado[c])
    );
  end
endmodule

// File: tb/tb_debouncer_entrada.sv
// tb_debouncer_entrada: directed vector table plus reset corner sequences for the debouncer
module tb_debouncer_entrada;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [1:0] e;
    logic [1:0] s;
    logic [1:0] o;
  } vec_t;
  vec_t tab[$];
  logic [1:0] hist1, hist2;
  debouncer_entrada_if #(.N_CANAIS(2)) bus ();
  debouncer_entrada_if #(.N_CANAIS(2)) bus1 ();
  assign bus1.entrada = bus.entrada;
  debouncer_entrada #(.N_CANAIS(2), .CICLOS_ESTAVEIS(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  debouncer_entrada #(.N_CANAIS(2), .CICLOS_ESTAVEIS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  always #5 clk = ~clk;

  task automatic chk(input string nome, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", nome, got, exp);
    end
  endtask

  task automatic step(input string nome, input logic [1:0] e, input logic [1:0] s, input logic [1:0] o);
    bus.entrada = e;
    @(posedge clk);
    #1;
    chk({nome, ".saida"}, bus.saida, s);
    chk({nome, ".ocupado"}, bus.ocupado, o);
  endtask

  task automatic add(input logic [1:0] e, input logic [1:0] s, input logic [1:0] o);
    tab.push_back('{e: e, s: s, o: o});
  endtask

  initial begin
    // rise on both channels after reset
    add(2'b11, 2'b00, 2'b00); add(2'b11, 2'b00, 2'b00); add(2'b11, 2'b00, 2'b11);
    add(2'b11, 2'b00, 2'b11); add(2'b11, 2'b00, 2'b11); add(2'b11, 2'b11, 2'b00);
    add(2'b11, 2'b11, 2'b00);
    // fall on both channels
    add(2'b00, 2'b11, 2'b00); add(2'b00, 2'b11, 2'b00); add(2'b00, 2'b11, 2'b11);
    add(2'b00, 2'b11, 2'b11); add(2'b00, 2'b11, 2'b11); add(2'b00, 2'b00, 2'b00);
    // three-cycle glitch on channel 0 is discarded
    add(2'b01, 2'b00, 2'b00); add(2'b01, 2'b00, 2'b00); add(2'b01, 2'b00, 2'b01);
    add(2'b00, 2'b00, 2'b01); add(2'b00, 2'b00, 2'b01); add(2'b00, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00);
    // bounce 1,0,1,1,... on channel 0
    add(2'b01, 2'b00, 2'b00); add(2'b00, 2'b00, 2'b00); add(2'b01, 2'b00, 2'b01);
    add(2'b01, 2'b00, 2'b00); add(2'b01, 2'b00, 2'b01); add(2'b01, 2'b00, 2'b01);
    add(2'b01, 2'b00, 2'b01); add(2'b01, 2'b01, 2'b00);
    // channel 0 falls alone
    add(2'b00, 2'b01, 2'b00); add(2'b00, 2'b01, 2'b00); add(2'b00, 2'b01, 2'b01);
    add(2'b00, 2'b01, 2'b01); add(2'b00, 2'b01, 2'b01); add(2'b00, 2'b00, 2'b00);
    // channel 1 rises two cycles after channel 0
    add(2'b01, 2'b00, 2'b00); add(2'b01, 2'b00, 2'b00); add(2'b11, 2'b00, 2'b01);
    add(2'b11, 2'b00, 2'b01); add(2'b11, 2'b00, 2'b11); add(2'b11, 2'b01, 2'b10);
    add(2'b11, 2'b01, 2'b10); add(2'b11, 2'b11, 2'b00);

    bus.entrada = 2'b11;
    #3;
    chk("reset.saida", bus.saida, 2'b00);
    chk("reset.ocupado", bus.ocupado, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held.saida", bus.saida, 2'b00);
    rst = 1'b0;
    hist1 = 2'b00;
    hist2 = 2'b00;
    for (int i = 0; i < tab.size(); i++) begin
      step($sformatf("vec%0d", i), tab[i].e, tab[i].s, tab[i].o);
      // with a one-cycle window saida lags entrada by the two sync flops plus the output register
      chk($sformatf("vec%0d.c1_saida", i), bus1.saida, hist2);
      chk($sformatf("vec%0d.c1_ocupado", i), bus1.ocupado, 2'b00);
      hist2 = hist1;
      hist1 = tab[i].e;
    end

    #2 rst = 1'b1;
    #1;
    chk("rst_async.saida", bus.saida, 2'b00);
    chk("rst_async.ocupado", bus.ocupado, 2'b00);
    chk("rst_async.c1_saida", bus1.saida, 2'b00);
    #2 rst = 1'b0;
    step("mid1", 2'b01, 2'b00, 2'b00);
    step("mid2", 2'b01, 2'b00, 2'b00);
    step("mid3", 2'b01, 2'b00, 2'b01);
    step("mid4", 2'b01, 2'b00, 2'b01);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.saida", bus.saida, 2'b00);
    chk("rst_mid.ocupado", bus.ocupado, 2'b00);
    #2 rst = 1'b0;
    step("after1", 2'b01, 2'b00, 2'b00);
    step("after2", 2'b01, 2'b00, 2'b00);
    step("after3", 2'b01, 2'b00, 2'b01);
    step("after4", 2'b01, 2'b00, 2'b01);
    step("after5", 2'b01, 2'b00, 2'b01);
    step("after6", 2'b01, 2'b01, 2'b00);
    step("after7", 2'b01, 2'b01, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
